// File: rtl/ntt_io_gearbox.sv
// ntt_io_gearbox: serial<->vector gearbox between board I/O and the NTT core.
// Packs serial beats into core vectors and frames them. Core output vectors
// are buffered in a small FIFO and streamed back out serially.
// Ports: clk, rst (async, active-high)
//   s_valid/s_ready/s_data             serial input, SER_LANES words per beat
//   core_in_valid/start/data           one-cycle vector pulse to the core
//   core_out_valid/data                core result vectors (no backpressure)
//   m_valid/m_ready/m_data/m_first     serial output, first word of frame marked
//   ovf_err                            sticky: core vector arrived with FIFO full
// Option: define NTT_GEARBOX_BITREV_EN to map word n <-> lane bitrev(n).
module ntt_io_gearbox #(
    parameter int DATA_WIDTH      = 28,
    parameter int INPUT_PER_CYCLE = 32,
    parameter int SER_LANES       = 1,
    parameter int VECS_PER_FRAME  = 128,
    parameter int VEC_FIFO_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [SER_LANES*DATA_WIDTH-1:0]       s_data,
    output logic                                  core_in_valid,
    output logic                                  core_in_start,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH-1:0] core_in_data,
    input  logic                                  core_out_valid,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH-1:0] core_out_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [SER_LANES*DATA_WIDTH-1:0]       m_data,
    output logic                                  m_first,
    output logic                                  ovf_err
);

    localparam int BPV  = INPUT_PER_CYCLE / SER_LANES;
    localparam int BW   = (BPV > 1) ? $clog2(BPV) : 1;
    localparam int LW   = (INPUT_PER_CYCLE > 1) ? $clog2(INPUT_PER_CYCLE) : 1;
    localparam int VW   = (VECS_PER_FRAME > 1) ? $clog2(VECS_PER_FRAME) : 1;
    localparam int PW   = (VEC_FIFO_DEPTH > 1) ? $clog2(VEC_FIFO_DEPTH) : 1;
    localparam int CW   = PW + 1;
    localparam int VECW = INPUT_PER_CYCLE * DATA_WIDTH;

    // Lane that holds serial word s of beat 'beat'.
    function automatic logic [LW-1:0] word_lane(input logic [BW-1:0] beat,
                                                input int s);
        logic [LW-1:0] n;
        logic [LW-1:0] r;
        n = LW'(int'(beat) * SER_LANES + s);
`ifdef NTT_GEARBOX_BITREV_EN
        for (int b = 0; b < LW; b++) r[b] = n[LW-1-b];
`else
        r = n;
`endif
        return r;
    endfunction

    logic [BW-1:0]   in_beat_q, in_beat_d;
    logic [VW-1:0]   in_vec_q, in_vec_d;
    logic [VECW-1:0] asm_q, asm_d;
    logic            civ_q, civ_d;
    logic            cis_q, cis_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   infl_q, infl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]   out_beat_q, out_beat_d;
    logic [VW-1:0]   out_vec_q, out_vec_d;
    logic [VECW-1:0] mem_q [VEC_FIFO_DEPTH];

    logic            s_acc, last_in, last_out;
    logic            full, push, pop, dec;
    logic [CW-1:0]   free, pend_total;
    logic [VECW-1:0] head;

    // In-flight includes a pulse being issued this cycle, so a vector can
    // never be started without a FIFO slot reserved for its result.
    assign free       = CW'(VEC_FIFO_DEPTH) - cnt_q;
    assign pend_total = infl_q + CW'(civ_q);
    assign s_ready    = !rst && !ovf_q && (free > pend_total);
    assign full       = (cnt_q == CW'(VEC_FIFO_DEPTH));
    assign m_valid    = (cnt_q != '0);
    assign m_first    = m_valid && (out_beat_q == '0) && (out_vec_q == '0);

    assign core_in_valid = civ_q;
    assign core_in_start = cis_q;
    assign core_in_data  = asm_q;
    assign ovf_err       = ovf_q;

    always_comb begin
        s_acc      = s_valid && s_ready;
        last_in    = (in_beat_q == BW'(BPV - 1));
        last_out   = (out_beat_q == BW'(BPV - 1));
        push       = core_out_valid && !full;
        pop        = m_valid && m_ready && last_out;
        dec        = core_out_valid && (pend_total != '0);

        asm_d      = asm_q;
        in_beat_d  = in_beat_q;
        in_vec_d   = in_vec_q;
        civ_d      = s_acc && last_in;
        cis_d      = s_acc && last_in && (in_vec_q == '0);
        if (s_acc) begin
            for (int s = 0; s < SER_LANES; s++) begin
                asm_d[word_lane(in_beat_q, s)*DATA_WIDTH +: DATA_WIDTH] =
                    s_data[s*DATA_WIDTH +: DATA_WIDTH];
            end
            in_beat_d = last_in ? '0 : in_beat_q + BW'(1);
            if (last_in) begin
                in_vec_d = (in_vec_q == VW'(VECS_PER_FRAME - 1)) ?
                           '0 : in_vec_q + VW'(1);
            end
        end

        infl_d   = pend_total - CW'(dec);
        ovf_d    = ovf_q || (core_out_valid && full);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);

        out_beat_d = out_beat_q;
        out_vec_d  = out_vec_q;
        if (m_valid && m_ready) begin
            out_beat_d = last_out ? '0 : out_beat_q + BW'(1);
        end
        if (pop) begin
            out_vec_d = (out_vec_q == VW'(VECS_PER_FRAME - 1)) ?
                        '0 : out_vec_q + VW'(1);
        end

        head   = mem_q[rd_ptr_q];
        m_data = '0;
        if (m_valid) begin
            for (int s = 0; s < SER_LANES; s++) begin
                m_data[s*DATA_WIDTH +: DATA_WIDTH] =
                    head[word_lane(out_beat_q, s)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_beat_q  <= '0;
            in_vec_q   <= '0;
            asm_q      <= '0;
            civ_q      <= 1'b0;
            cis_q      <= 1'b0;
            ovf_q      <= 1'b0;
            infl_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_beat_q <= '0;
            out_vec_q  <= '0;
        end else begin
            in_beat_q  <= in_beat_d;
            in_vec_q   <= in_vec_d;
            asm_q      <= asm_d;
            civ_q      <= civ_d;
            cis_q      <= cis_d;
            ovf_q      <= ovf_d;
            infl_q     <= infl_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_beat_q <= out_beat_d;
            out_vec_q  <= out_vec_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= core_out_data;
    end

endmodule
